// File: rtl/tetris_key_pkg.sv
// Shared command codes and key indices for the Tetris key path and game-logic FSM.
package tetris_key_pkg;

    localparam int unsigned CMD_W    = 3;
    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned CNT_W    = 8;

    localparam logic [CMD_W-1:0] CMD_NONE  = 3'd0;
    localparam logic [CMD_W-1:0] CMD_ROT   = 3'd1;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd3;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd4;

    // Pending-bit index; lower index wins arbitration.
    typedef enum logic [1:0] {
        KEY_ROT   = 2'd0,
        KEY_LEFT  = 2'd1,
        KEY_RIGHT = 2'd2,
        KEY_DOWN  = 2'd3
    } key_idx_e;

    // Command codes follow key index order, starting at CMD_ROT.
    function automatic logic [CMD_W-1:0] key_to_cmd(input key_idx_e idx);
        return CMD_W'(idx) + CMD_ROT;
    endfunction

endpackage

// File: rtl/key_cmd_fifo.sv
// Show-ahead synchronous FIFO of command codes with level and full/empty flags.
module key_cmd_fifo
    import tetris_key_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] data_in,
    input  logic             pop,
    input  logic             flush,
    output logic [CMD_W-1:0] head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? CMD_NONE : mem[rd_ptr];

    // Pointers and level; flush empties the queue, pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Entry storage; contents are only observed while non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= CMD_NONE;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/key_cmd_queue.sv
// Turns debounced key pulses into an arbitrated, buffered stream of game commands.
module key_cmd_queue
    import tetris_key_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_rot_p,
    input  logic             key_left_p,
    input  logic             key_right_p,
    input  logic             key_down_p,
    input  logic             flush,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic [CNT_W-1:0] coalesce_cnt
);

    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] clear;
    logic [NUM_KEYS-1:0] merge;
    key_idx_e            sel_idx;
    logic                has_sel;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic [2:0]          merge_n;
    logic [CNT_W:0]      coal_sum;

    assign keys      = {key_down_p, key_right_p, key_left_p, key_rot_p};
    assign cmd_valid = ~fifo_empty;
    assign pop       = cmd_valid & cmd_ready & ~flush;

    // Fixed-priority arbiter: ROT > LEFT > RIGHT > DOWN.
    always_comb begin
        sel_idx = KEY_ROT;
        has_sel = |pending;
        if (pending[0])      sel_idx = KEY_ROT;
        else if (pending[1]) sel_idx = KEY_LEFT;
        else if (pending[2]) sel_idx = KEY_RIGHT;
        else if (pending[3]) sel_idx = KEY_DOWN;
    end

    // A slot frees up either when not full or when the head leaves this same cycle.
    assign push  = has_sel & (~fifo_full | pop) & ~flush;
    assign clear = push ? (NUM_KEYS'(1) << sel_idx) : '0;
    assign merge = keys & pending & ~clear;

    assign merge_n  = 3'(merge[0]) + 3'(merge[1]) + 3'(merge[2]) + 3'(merge[3]);
    assign coal_sum = {1'b0, coalesce_cnt} + (CNT_W + 1)'(merge_n);

    // Pending bits: a pulse on the bit being queued re-arms it as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clear) | keys;
        end
    end

    // Saturating count of presses absorbed by an already-pending press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coalesce_cnt <= '0;
        end else if (!flush) begin
            coalesce_cnt <= coal_sum[CNT_W] ? {CNT_W{1'b1}} : coal_sum[CNT_W-1:0];
        end
    end

    key_cmd_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .data_in (key_to_cmd(sel_idx)),
        .pop     (pop),
        .flush   (flush),
        .head    (cmd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_key_cmd_queue.sv
// Self-checking bench for key_cmd_queue: vector table, corner sequences, random vs queue model.
module tb_key_cmd_queue;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_rot_p, key_left_p, key_right_p, key_down_p;
    logic             flush;
    logic             cmd_valid;
    logic [2:0]       cmd_data;
    logic             cmd_ready;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       coalesce_cnt;

    key_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_rot_p    (key_rot_p),
        .key_left_p   (key_left_p),
        .key_right_p  (key_right_p),
        .key_down_p   (key_down_p),
        .flush        (flush),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .fifo_level   (fifo_level),
        .coalesce_cnt (coalesce_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of codes, a set of waiting keys, a press counter.
    bit [2:0] mq[$];
    bit [3:0] mpend;
    int       mcoal;

    int obs_valid, obs_data, obs_level, obs_coal;
    int got[$];

    typedef struct {
        logic [3:0] keys;
        logic       rdy;
        logic       fl;
        int         v;
        int         d;
        int         lvl;
    } vec_t;
    vec_t tbl[18];

    function automatic int pack(input int v, input int d, input int l, input int c);
        return (c << 8) | (v << 7) | (d << 4) | l;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        mpend = '0;
        mcoal = 0;
    endtask

    task automatic model_update(input bit [3:0] k, input bit rdy, input bit fl);
        bit pop_now;
        bit room;
        int sel;
        if (fl) begin
            mq.delete();
            mpend = '0;
            return;
        end
        pop_now = (mq.size() != 0) && rdy;
        room    = (mq.size() < DEPTH) || pop_now;
        sel = -1;
        for (int i = 0; i < 4; i++) if (mpend[i] && sel < 0) sel = i;
        if (pop_now) void'(mq.pop_front());
        if (sel >= 0 && room) begin
            mq.push_back(3'(sel + 1));
            mpend[sel] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                if (mpend[i]) mcoal = (mcoal < 255) ? mcoal + 1 : 255;
                mpend[i] = 1'b1;
            end
        end
    endtask

    // One clock cycle: sample outputs, compare to model, drive inputs, advance model.
    task automatic step(input bit [3:0] k, input bit rdy, input bit fl);
        @(negedge clk);
        obs_valid = int'(cmd_valid);
        obs_data  = int'(cmd_data);
        obs_level = int'(fifo_level);
        obs_coal  = int'(coalesce_cnt);
        check("model", pack(obs_valid, obs_data, obs_level, obs_coal),
              pack(int'(mq.size() != 0), (mq.size() != 0) ? int'(mq[0]) : 0,
                   mq.size(), mcoal));
        key_rot_p   = k[0];
        key_left_p  = k[1];
        key_right_p = k[2];
        key_down_p  = k[3];
        cmd_ready   = rdy;
        flush       = fl;
        @(posedge clk);
        model_update(k, rdy, fl);
    endtask

    // Pop until the queue shows empty, bounded; collected codes land in got.
    task automatic drain();
        got.delete();
        for (int i = 0; i < 40; i++) begin
            step(4'b0000, 1'b1, 1'b0);
            if (obs_valid != 0) got.push_back(obs_data);
            else if (got.size() != 0) break;
        end
    endtask

    task automatic check_seq(input string name, input int exp[]);
        check({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_%0d", name, i), (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    initial begin
        int seq_a[] = '{1, 2, 3, 4, 1, 2};
        int seq_b[] = '{1, 2, 3, 4, 4};

        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[1]  = '{4'b0010, 1'b1, 1'b0, 0, 0, 0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 1, 2, 1};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[5]  = '{4'b1111, 1'b0, 1'b0, 0, 0, 0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 0, 0, 0};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1, 1, 1};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1, 1, 2};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1, 1, 3};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1, 1, 4};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 1, 1, 4};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 1, 2, 3};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 1, 3, 2};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 1, 4, 1};
        tbl[15] = '{4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[16] = '{4'b0000, 1'b0, 1'b1, 0, 0, 0};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 0, 0, 0};

        key_rot_p = 0; key_left_p = 0; key_right_p = 0; key_down_p = 0;
        flush = 0; cmd_ready = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset", pack(int'(cmd_valid), int'(cmd_data), int'(fifo_level),
                               int'(coalesce_cnt)), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: single LEFT latency, then four simultaneous presses.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].keys, tbl[i].rdy, tbl[i].fl);
            check($sformatf("row%0d", i), pack(obs_valid, obs_data, obs_level, obs_coal),
                  pack(tbl[i].v, tbl[i].d, tbl[i].lvl, 0));
        end

        // Six separate presses while stalled: four queued, ROT and LEFT wait.
        step(4'b0001, 0, 0); step(4'b0010, 0, 0); step(4'b0100, 0, 0);
        step(4'b1000, 0, 0); step(4'b0010, 0, 0); step(4'b0001, 0, 0);
        step(4'b0000, 0, 0); step(4'b0000, 0, 0);
        check("a_level", obs_level, 4);
        check("a_coal", obs_coal, 0);
        drain();
        check_seq("a_drain", seq_a);

        // Merging into a held DOWN press, then saturation.
        step(4'b1111, 0, 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 0, 0);
        step(4'b1000, 0, 0);
        for (int i = 0; i < 3; i++) step(4'b1000, 0, 0);
        step(4'b0000, 0, 0);
        check("b_coal3", obs_coal, 3);
        check("b_level", obs_level, 4);
        for (int i = 0; i < 300; i++) step(4'b1000, 0, 0);
        step(4'b0000, 0, 0);
        check("b_coal_sat", obs_coal, 255);
        drain();
        check_seq("b_drain", seq_b);

        // Full queue streaming at one command per cycle.
        step(4'b1111, 0, 0); step(4'b0000, 0, 0); step(4'b0000, 0, 0);
        step(4'b0001, 0, 0); step(4'b0000, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(4'(1 << (i % 4)), 1, 0);
            check($sformatf("c_level%0d", i), obs_level, 4);
        end
        drain();

        // Flush with entries queued, presses waiting and a pulse in the flush cycle.
        step(4'b1111, 0, 0); step(4'b0000, 0, 0); step(4'b0000, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 1);
        check("d_level_pre", obs_level, 3);
        for (int i = 0; i < 6; i++) begin
            step(4'b0000, 1, 0);
            check($sformatf("d_empty%0d", i), pack(obs_valid, obs_data, obs_level, 0), 0);
        end

        // Asynchronous reset in the middle of a drain.
        step(4'b1111, 0, 0);
        for (int i = 0; i < 5; i++) step(4'b0000, 0, 0);
        step(4'b0000, 1, 0); step(4'b0000, 1, 0);
        #2 rst_n = 1'b0;
        #1 check("e_async_rst", pack(int'(cmd_valid), int'(cmd_data), int'(fifo_level),
                                     int'(coalesce_cnt)), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bit [3:0] k;
            for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 3) == 0);
            step(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Converts the single-cycle key-press pulses from the per-key debouncers into an ordered stream of Tetris game commands for the game engine. Sits directly downstream of the debouncers and upstream of the game-logic FSM. Simultaneous presses are arbitrated, and presses are buffered while the engine is busy, so no press is lost unless the same key is pressed again before its first press is queued.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: width of fifo_level.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_rot_p  in  1  one-cycle press pulse, rotate.
- key_left_p  in  1  one-cycle press pulse, move left.
- key_right_p  in  1  one-cycle press pulse, move right.
- key_down_p  in  1  one-cycle press pulse, soft drop.
- flush  in  1  synchronous clear of the queue and all pending presses (game over / restart).
- cmd_valid  out  1  cmd_data holds a valid command.
- cmd_data  out  3  command code: ROT=3'd1, LEFT=3'd2, RIGHT=3'd3, DOWN=3'd4.
- cmd_ready  in  1  engine accepts the command this cycle.
- fifo_level  out  LVL_W  number of queued entries, 0..DEPTH.
- coalesce_cnt  out  8  saturating count of presses merged into an already-pending press.

## Operation
- Pending stage: 4 pending bits (rot, left, right, down), all 0 at reset.
  - A pulse on a key sets that key's bit.
  - If the bit is already set and is not being cleared this cycle, the pulse is merged and coalesce_cnt increments, saturating at 255.
- Arbiter (combinational): selects the highest-priority pending bit, in the order ROT > LEFT > RIGHT > DOWN.
  - Pushes the matching code into the FIFO when push is allowed, and clears that bit at the same edge.
  - If a new pulse hits the bit being cleared in the same cycle, the bit stays set. That is a new press, not a merge.
- Push allowed when fifo_level < DEPTH, or when fifo_level == DEPTH and a pop happens in the same cycle.
- FIFO is show-ahead:
  - cmd_valid = (fifo_level != 0).
  - cmd_data = head entry, or 3'd0 when empty.
  - Pop on cmd_valid & cmd_ready.
  - cmd_ready while empty is ignored.
- Simultaneous push and pop leaves fifo_level unchanged. Pointers wrap modulo DEPTH.
- While the FIFO is full and no pop occurs, pending bits hold. Presses wait and are not dropped.
- flush:
  - Clears the FIFO pointers, fifo_level and all pending bits at the next edge.
  - Key pulses and pops in the flush cycle are discarded.
  - coalesce_cnt is not cleared; only reset clears it.
- Reset values: cmd_valid=0, cmd_data=3'd0, fifo_level=0, coalesce_cnt=0, pending=4'b0, pointers=0.
- Reset asserted mid-operation returns every output to its reset value asynchronously.

## Timing
- Latency, idle queue: pulse in cycle N → pending set at end of N → push at end of N+1 → cmd_valid=1 in cycle N+2.
- One push per cycle at most. With k simultaneous pulses into an empty queue, the commands appear in priority order, one per cycle, with the first visible at N+2.
- Pop: cmd_valid & cmd_ready in cycle M → the next entry, or cmd_valid=0, is visible in M+1.
- Full queue with cmd_ready held high: one push and one pop per cycle, throughput 1 command/cycle.
- All outputs are registered or derived from registered state. There is no combinational path from key_*_p or cmd_ready to cmd_valid or cmd_data.

## Structure
- Shared package tetris_key_pkg:
  - CMD_W=3.
  - Command code constants CMD_NONE=0, CMD_ROT=1, CMD_LEFT=2, CMD_RIGHT=3, CMD_DOWN=4.
  - Also used by the game-logic FSM.
- Sub-module key_cmd_fifo:
  - Parameterized synchronous FIFO (DEPTH, width CMD_W).
  - Provides push, pop, flush, show-ahead head, level and full/empty flags.
- Top level key_cmd_queue holds the pending bits, arbiter, coalesce counter and the key_cmd_fifo instance.

## Test plan
- Single LEFT pulse at cycle 10, cmd_ready=1 → cmd_valid=1, cmd_data=3'd2 in cycle 12 only; fifo_level 0→1→0.
- ROT, LEFT, RIGHT and DOWN pulsed in the same cycle, cmd_ready=0 → fifo_level reaches 4. Then cmd_ready=1 → codes 1, 2, 3, 4 in consecutive cycles.
- cmd_ready=0, 6 distinct-cycle pulses: ROT, LEFT, RIGHT, DOWN, then LEFT, ROT → FIFO holds 1, 2, 3, 4 and pending={rot,left}. Draining yields 1, 2, 3, 4, 1, 2 and coalesce_cnt stays 0.
- FIFO full, DOWN pending, DOWN pulsed 3 more times → coalesce_cnt=3, and only one DOWN is queued after the drain. 300 merged presses → coalesce_cnt=255.
- Full FIFO with cmd_ready=1 and a pulse every cycle → fifo_level stays at 4 and the output order is preserved.
- flush with 3 entries queued, 2 pending bits set and a pulse in the flush cycle → cmd_valid=0 and fifo_level=0 next cycle, with no commands afterwards. Asserting rst_n=0 mid-drain → all outputs return to reset values immediately.
